flexka_cmd_sequencer: RTL and testbench

- Front-end controller for the FlexKA accelerator core.
- Buffers host commands in a small FIFO and issues them to the core one at a time.
- Waits for core completion, then captures the result data and elapsed-cycle count into a response register with a valid/ready handshake.
- Sits between the host command interface and the core's command and state ports.

---
 rtl/flexka_cmd_sequencer_if.sv | 36 +++
 rtl/flexka_cmd_sequencer.sv | 151 +++++++++++++++
 tb/tb_flexka_cmd_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/flexka_cmd_sequencer_if.sv
// Host command, core issue/completion and response bundle of the FlexKA command sequencer.
interface flexka_cmd_sequencer_if #(
    parameter int DATA_W = 64,
    parameter int CYC_W  = 32,
    parameter int DEPTH  = 4
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [3:0]               cmd_opcode;
    logic [DATA_W-1:0]        cmd_data;
    logic                     acc_cmd_valid;
    logic [3:0]               acc_cmd_opcode;
    logic [DATA_W-1:0]        acc_cmd_data;
    logic                     acc_done;
    logic [DATA_W-1:0]        acc_out_data;
    logic [CYC_W-1:0]         acc_elapsed;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DATA_W-1:0]        rsp_data;
    logic [CYC_W-1:0]         rsp_cycles;
    logic [1:0]               rsp_status;
    logic [1:0]               seq_state;
    logic [$clog2(DEPTH):0]   pending;

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_data, acc_done, acc_out_data, acc_elapsed, rsp_ready,
        output cmd_ready, acc_cmd_valid, acc_cmd_opcode, acc_cmd_data,
               rsp_valid, rsp_data, rsp_cycles, rsp_status, seq_state, pending
    );

    modport master (
        output cmd_valid, cmd_opcode, cmd_data, acc_done, acc_out_data, acc_elapsed, rsp_ready,
        input  cmd_ready, acc_cmd_valid, acc_cmd_opcode, acc_cmd_data,
               rsp_valid, rsp_data, rsp_cycles, rsp_status, seq_state, pending
    );
endinterface

// File: rtl/flexka_cmd_sequencer.sv
// FlexKA command sequencer: FIFO-buffered host commands issued one at a time to the core.
// Optional completion watchdog enabled by defining FLEXKA_SEQ_TIMEOUT_EN.
module flexka_cmd_sequencer #(
    parameter int DATA_W  = 64,
    parameter int CYC_W   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1048575
) (
    input  logic                  clk,
    input  logic                  rstn,
    flexka_cmd_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [3:0]        fifo_opcode [DEPTH];
    logic [DATA_W-1:0] fifo_data   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              cmd_ready, push, pop, issue, rsp_valid, timeout_hit;
    logic [3:0]        issue_opcode;
    logic [DATA_W-1:0] issue_data, rsp_data;
    logic [CYC_W-1:0]  rsp_cycles;
    logic [1:0]        rsp_status;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push then.
    assign cmd_ready = (count != FULL) || pop;
    assign push      = bus.cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_opcode[wr_ptr] <= bus.cmd_opcode;
            fifo_data[wr_ptr]   <= bus.cmd_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        issue      = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                issue      = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (bus.acc_done || timeout_hit) state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issue_opcode <= '0;
            issue_data   <= '0;
        end else if (pop) begin
            issue_opcode <= fifo_opcode[rd_ptr];
            issue_data   <= fifo_data[rd_ptr];
        end
    end

`ifdef FLEXKA_SEQ_TIMEOUT_EN
    localparam logic [CYC_W-1:0] TIMEOUT_CNT = CYC_W'(TIMEOUT);
    logic [CYC_W-1:0] wd_count;

    // Counts WAIT cycles; the expiring cycle is the TIMEOUT-th one spent in WAIT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)               wd_count <= '0;
        else if (state == ISSUE) wd_count <= '0;
        else if (state == WAIT)  wd_count <= wd_count + 1'b1;
    end

    assign timeout_hit = (state == WAIT) && !bus.acc_done && (wd_count + 1'b1 == TIMEOUT_CNT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                             rsp_status <= 2'b00;
        else if (state == WAIT && bus.acc_done) rsp_status <= 2'b00;
        else if (timeout_hit)                  rsp_status <= 2'b01;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign rsp_status     = 2'b00;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_data   <= '0;
            rsp_cycles <= '0;
        end else if (state == WAIT && bus.acc_done) begin
            rsp_data   <= bus.acc_out_data;
            rsp_cycles <= bus.acc_elapsed;
        end
`ifdef FLEXKA_SEQ_TIMEOUT_EN
        else if (timeout_hit) begin
            rsp_data   <= '0;
            rsp_cycles <= TIMEOUT_CNT;
        end
`endif
    end

    assign bus.cmd_ready      = cmd_ready;
    assign bus.acc_cmd_valid  = issue;
    assign bus.acc_cmd_opcode = issue_opcode;
    assign bus.acc_cmd_data   = issue_data;
    assign bus.rsp_valid      = rsp_valid;
    assign bus.rsp_data       = rsp_data;
    assign bus.rsp_cycles     = rsp_cycles;
    assign bus.rsp_status     = rsp_status;
    assign bus.seq_state      = state;
    assign bus.pending        = count;
endmodule

// File: tb/tb_flexka_cmd_sequencer.sv
// Scoreboard bench for flexka_cmd_sequencer: a cycle-level occupancy/busy model predicts
// issues and responses; a negedge monitor compares the DUT against the expected queues.
`timescale 1ns/1ps
module tb_flexka_cmd_sequencer;
    localparam int DATA_W  = 64;
    localparam int CYC_W   = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 50;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    flexka_cmd_sequencer_if #(.DATA_W(DATA_W), .CYC_W(CYC_W), .DEPTH(DEPTH)) bus ();

    flexka_cmd_sequencer #(
        .DATA_W(DATA_W), .CYC_W(CYC_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0]        op;
        logic [DATA_W-1:0] data;
        int                cyc;
    } cmd_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [CYC_W-1:0]  cycles;
        logic [1:0]        status;
    } rsp_t;

    cmd_t wait_q[$];
    cmd_t exp_issue_q[$];
    rsp_t exp_rsp_q[$];
    bit   busy      = 1'b0;
    bit   resp_pend = 1'b0;
    int   issue_cyc = 0;
    int   cyc       = 0;
    int   errors    = 0;
    int   checks    = 0;
    logic [3:0]        last_op   = '0;
    logic [DATA_W-1:0] last_data = '0;
    rsp_t              last_rsp  = '{'0, '0, 2'b00};

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input bit valid, input logic [3:0] opcode, input logic [DATA_W-1:0] data,
                                 input bit done, input logic [DATA_W-1:0] out,
                                 input logic [CYC_W-1:0] elapsed, input bit ready);
        @(posedge clk);
        #1;
        bus.cmd_valid    = valid;
        bus.cmd_opcode   = opcode;
        bus.cmd_data     = data;
        bus.acc_done     = done;
        bus.acc_out_data = out;
        bus.acc_elapsed  = elapsed;
        bus.rsp_ready    = ready;
    endtask

    task automatic idleCycles(input int n, input bit ready);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, '0, 1'b0, '0, '0, ready);
    endtask

    task automatic randomStimulus(input int n, input int p_cmd, input int p_done, input int p_rdy);
        for (int i = 0; i < n; i++)
            applyStimulus($urandom_range(99) < p_cmd, 4'($urandom), {$urandom, $urandom},
                          $urandom_range(99) < p_done, {$urandom, $urandom}, $urandom,
                          $urandom_range(99) < p_rdy);
    endtask

    task automatic drainQueue();
        int n = 0;
        while ((wait_q.size() != 0 || busy) && n < 400) begin
            applyStimulus(1'b0, 4'h0, '0, 1'b1, {$urandom, $urandom}, $urandom, 1'b1);
            n++;
        end
        idleCycles(2, 1'b0);
        @(negedge clk);
        checkOutput("drain_state", 64'(bus.seq_state), 64'(0));
        checkOutput("drain_pending", 64'(bus.pending), 64'(0));
    endtask

    // Reference model: commands wait in order, one may be in flight, and the next pops
    // in the first cycle with nothing in flight; it issues the cycle after the pop.
    initial begin
        bit   pop_now;
        bit   accept;
        cmd_t c;
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                wait_q.delete();
                exp_issue_q.delete();
                exp_rsp_q.delete();
                busy      = 1'b0;
                resp_pend = 1'b0;
                last_op   = '0;
                last_data = '0;
                last_rsp  = '{'0, '0, 2'b00};
            end else begin
                pop_now = !busy && wait_q.size() != 0;
                accept  = bus.cmd_valid && (wait_q.size() < DEPTH || pop_now);
                if (resp_pend && bus.rsp_ready) begin
                    busy      = 1'b0;
                    resp_pend = 1'b0;
                end else if (busy && !resp_pend && cyc > issue_cyc) begin
                    if (bus.acc_done) begin
                        resp_pend = 1'b1;
                        exp_rsp_q.push_back('{bus.acc_out_data, bus.acc_elapsed, 2'b00});
                    end
`ifdef FLEXKA_SEQ_TIMEOUT_EN
                    else if (cyc - issue_cyc == TIMEOUT) begin
                        resp_pend = 1'b1;
                        exp_rsp_q.push_back('{'0, CYC_W'(TIMEOUT), 2'b01});
                    end
`endif
                end
                if (pop_now) begin
                    c         = wait_q.pop_front();
                    c.cyc     = cyc + 1;
                    issue_cyc = cyc + 1;
                    busy      = 1'b1;
                    exp_issue_q.push_back(c);
                end
                if (accept) wait_q.push_back('{bus.cmd_opcode, bus.cmd_data, cyc});
                cyc++;
            end
        end
    end

    initial begin
        cmd_t ic;
        rsp_t rc;
        forever begin
            @(negedge clk);
            if (rstn) begin
                checkOutput("pending", 64'(bus.pending), 64'(wait_q.size()));
                checkOutput("cmd_ready", 64'(bus.cmd_ready),
                            64'(wait_q.size() < DEPTH || (!busy && wait_q.size() != 0)));
                checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(resp_pend));
                if (bus.acc_cmd_valid) begin
                    if (exp_issue_q.size() == 0) begin
                        checkOutput("unexpected_issue", 64'(bus.acc_cmd_valid), 64'(0));
                    end else begin
                        ic = exp_issue_q.pop_front();
                        checkOutput("issue_cycle", 64'(cyc), 64'(ic.cyc));
                        checkOutput("issue_opcode", 64'(bus.acc_cmd_opcode), 64'(ic.op));
                        checkOutput("issue_data", bus.acc_cmd_data, ic.data);
                        last_op   = ic.op;
                        last_data = ic.data;
                    end
                end else begin
                    if (exp_issue_q.size() != 0 && exp_issue_q[0].cyc <= cyc) begin
                        ic = exp_issue_q.pop_front();
                        checkOutput("missing_issue", 64'(bus.acc_cmd_valid), 64'(1));
                    end
                    checkOutput("hold_opcode", 64'(bus.acc_cmd_opcode), 64'(last_op));
                    checkOutput("hold_data", bus.acc_cmd_data, last_data);
                end
                if (bus.rsp_valid && exp_rsp_q.size() != 0) begin
                    rc = exp_rsp_q[0];
                    checkOutput("rsp_data", bus.rsp_data, rc.data);
                    checkOutput("rsp_cycles", 64'(bus.rsp_cycles), 64'(rc.cycles));
                    checkOutput("rsp_status", 64'(bus.rsp_status), 64'(rc.status));
                    if (bus.rsp_ready) begin
                        void'(exp_rsp_q.pop_front());
                        last_rsp = rc;
                    end
                end else if (!bus.rsp_valid) begin
                    checkOutput("retain_rsp_data", bus.rsp_data, last_rsp.data);
                    checkOutput("retain_rsp_cycles", 64'(bus.rsp_cycles), 64'(last_rsp.cycles));
                    checkOutput("retain_rsp_status", 64'(bus.rsp_status), 64'(last_rsp.status));
                end
            end
        end
    end

    initial begin
        bus.cmd_valid    = 1'b0;
        bus.cmd_opcode   = '0;
        bus.cmd_data     = '0;
        bus.acc_done     = 1'b0;
        bus.acc_out_data = '0;
        bus.acc_elapsed  = '0;
        bus.rsp_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        checkOutput("reset_seq_state", 64'(bus.seq_state), 64'(0));
        checkOutput("reset_acc_valid", 64'(bus.acc_cmd_valid), 64'(0));
        checkOutput("reset_rsp_data", bus.rsp_data, 64'(0));

        $display("[TB] single command");
        applyStimulus(1'b1, 4'h1, 64'h1234, 1'b0, '0, '0, 1'b0);
        idleCycles(4, 1'b0);
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 64'hABCD, 32'd100, 1'b0);
        idleCycles(2, 1'b0);
        applyStimulus(1'b0, 4'h0, '0, 1'b0, '0, '0, 1'b1);
        idleCycles(2, 1'b0);

        $display("[TB] fill FIFO with core stalled");
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 4'(i + 2), {$urandom, $urandom}, 1'b0, '0, '0, 1'b0);
        idleCycles(2, 1'b0);
        @(negedge clk);
        checkOutput("full_pending", 64'(bus.pending), 64'(DEPTH));
        checkOutput("full_cmd_ready", 64'(bus.cmd_ready), 64'(0));

        $display("[TB] response backpressure");
        applyStimulus(1'b0, 4'h0, '0, 1'b1, {$urandom, $urandom}, $urandom, 1'b0);
        idleCycles(10, 1'b0);
        @(negedge clk);
        checkOutput("held_seq_state", 64'(bus.seq_state), 64'(3));
        applyStimulus(1'b0, 4'h0, '0, 1'b0, '0, '0, 1'b1);
        idleCycles(3, 1'b0);
        drainQueue();

        $display("[TB] spurious acc_done in IDLE and RESP");
        repeat (3) applyStimulus(1'b0, 4'h0, '0, 1'b1, {$urandom, $urandom}, $urandom, 1'b0);
        @(negedge clk);
        checkOutput("spurious_idle_state", 64'(bus.seq_state), 64'(0));
        applyStimulus(1'b1, 4'h9, 64'h99, 1'b0, '0, '0, 1'b0);
        idleCycles(3, 1'b0);
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 64'h5555, 32'd7, 1'b0);
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 64'hDEAD, 32'd9, 1'b0);
        idleCycles(1, 1'b0);
        applyStimulus(1'b0, 4'h0, '0, 1'b0, '0, '0, 1'b1);
        idleCycles(2, 1'b0);

        $display("[TB] async reset during WAIT");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 4'(i + 10), {$urandom, $urandom}, 1'b0, '0, '0, 1'b0);
        idleCycles(2, 1'b0);
        @(negedge clk);
        checkOutput("pre_reset_pending", 64'(bus.pending), 64'(2));
        @(posedge clk);
        #3 rstn = 1'b0;
        @(negedge clk);
        checkOutput("rst_pending", 64'(bus.pending), 64'(0));
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        checkOutput("rst_seq_state", 64'(bus.seq_state), 64'(0));
        checkOutput("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        @(posedge clk);
        #1 rstn = 1'b1;
        idleCycles(2, 1'b0);

`ifdef FLEXKA_SEQ_TIMEOUT_EN
        $display("[TB] watchdog timeout");
        applyStimulus(1'b1, 4'h7, 64'h77, 1'b0, '0, '0, 1'b0);
        idleCycles(TIMEOUT + 6, 1'b0);
        @(negedge clk);
        checkOutput("timeout_status", 64'(bus.rsp_status), 64'(1));
        checkOutput("timeout_cycles", 64'(bus.rsp_cycles), 64'(TIMEOUT));
        applyStimulus(1'b0, 4'h0, '0, 1'b0, '0, '0, 1'b1);
        idleCycles(2, 1'b0);
`endif

        $display("[TB] randomized traffic");
        randomStimulus(300, 50, 20, 70);
        randomStimulus(200, 85, 10, 30);
        drainQueue();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
